// File: rtl/dct_pkg.sv
// Shared types and constants for the DVP capture / YCbCr / 8x8 block front end.
// Conversion coefficients are Q8 fixed point, applied to 8-bit expanded RGB.
package dct_pkg;

    localparam int BLOCK_N = 8;

    localparam int Y_CH  = 0;
    localparam int CB_CH = 1;
    localparam int CR_CH = 2;

    localparam logic signed [17:0] COEF_Y_R  =  18'sd77;
    localparam logic signed [17:0] COEF_Y_G  =  18'sd150;
    localparam logic signed [17:0] COEF_Y_B  =  18'sd29;
    localparam logic signed [17:0] COEF_CB_R = -18'sd43;
    localparam logic signed [17:0] COEF_CB_G = -18'sd85;
    localparam logic signed [17:0] COEF_CB_B =  18'sd128;
    localparam logic signed [17:0] COEF_CR_R =  18'sd128;
    localparam logic signed [17:0] COEF_CR_G = -18'sd107;
    localparam logic signed [17:0] COEF_CR_B = -18'sd21;

    typedef struct packed {
        logic              valid;
        logic              sob;
        logic signed [8:0] data;
    } dctPort_t;

    typedef enum logic {
        RD_IDLE,
        RD_RUN
    } rd_state_t;

    function automatic logic [8:0] sat_u8(input logic signed [9:0] v);
        if (v < 0) begin
            return 9'd0;
        end
        if (v > 10'sd255) begin
            return 9'd255;
        end
        return 9'(v);
    endfunction

endpackage

// File: rtl/dvp_ycbcr_block_top_if.sv
// Camera input bundle plus the three DCT channel ports (index 0 = Y, 1 = Cb, 2 = Cr).
// master = camera/consumer side, slave = the block itself.
interface dvp_ycbcr_block_top_if;
    import dct_pkg::*;

    logic           vsync;
    logic           href;
    logic [7:0]     data;
    dctPort_t [2:0] out;

    modport master (output vsync, output href, output data, input out);
    modport slave  (input vsync, input href, input data, output out);

endinterface

// File: rtl/dvp_ycbcr_block_top_rgb565.sv
// RGB565 -> YCbCr, 2-cycle pipeline (sums, then shift/format); no backpressure, pix_vld passes through.
// Output format selected by LEVEL_SHIFT_EN: signed level-shifted, else unsigned JFIF with saturated chroma.
module rgb565_to_ycbcr
    import dct_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pix_vld,
    input  logic [15:0]       pix,
    output logic              ycc_vld,
    output logic signed [8:0] y_dat,
    output logic signed [8:0] cb_dat,
    output logic signed [8:0] cr_dat
);

    logic signed [17:0] r_x, g_x, b_x;
    logic signed [17:0] y_sum_d, cb_sum_d, cr_sum_d;
    logic signed [17:0] y_sum_q, cb_sum_q, cr_sum_q;
    logic               vld1_d, vld1_q;
    logic signed [8:0]  y9, cb9, cr9;
    logic signed [8:0]  y_d, cb_d, cr_d;
    logic signed [8:0]  y_q, cb_q, cr_q;
    logic               vld2_d, vld2_q;

    always_comb begin
        // Bit replication keeps full-scale 5/6-bit codes mapping to 255.
        r_x = $signed({10'd0, pix[15:11], pix[15:13]});
        g_x = $signed({10'd0, pix[10:5],  pix[10:9]});
        b_x = $signed({10'd0, pix[4:0],   pix[4:2]});

        y_sum_d  = COEF_Y_R  * r_x + COEF_Y_G  * g_x + COEF_Y_B  * b_x;
        cb_sum_d = COEF_CB_R * r_x + COEF_CB_G * g_x + COEF_CB_B * b_x;
        cr_sum_d = COEF_CR_R * r_x + COEF_CR_G * g_x + COEF_CR_B * b_x;
        vld1_d   = pix_vld;

        y9  = 9'(y_sum_q  >>> 8);
        cb9 = 9'(cb_sum_q >>> 8);
        cr9 = 9'(cr_sum_q >>> 8);
`ifdef LEVEL_SHIFT_EN
        y_d  = y9 - 9'sd128;
        cb_d = cb9;
        cr_d = cr9;
`else
        y_d  = y9;
        cb_d = $signed(sat_u8($signed({cb9[8], cb9}) + 10'sd128));
        cr_d = $signed(sat_u8($signed({cr9[8], cr9}) + 10'sd128));
`endif
        vld2_d = vld1_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_sum_q  <= '0;
            cb_sum_q <= '0;
            cr_sum_q <= '0;
            vld1_q   <= 1'b0;
            y_q      <= '0;
            cb_q     <= '0;
            cr_q     <= '0;
            vld2_q   <= 1'b0;
        end else begin
            y_sum_q  <= y_sum_d;
            cb_sum_q <= cb_sum_d;
            cr_sum_q <= cr_sum_d;
            vld1_q   <= vld1_d;
            y_q      <= y_d;
            cb_q     <= cb_d;
            cr_q     <= cr_d;
            vld2_q   <= vld2_d;
        end
    end

    assign ycc_vld = vld2_q;
    assign y_dat   = y_q;
    assign cb_dat  = cb_q;
    assign cr_dat  = cr_q;

endmodule

// File: rtl/dvp_ycbcr_block_top.sv
// DVP RGB565 capture -> YCbCr -> ping-pong 8-row band buffer -> 8x8 blocks on Y/Cb/Cr (LEVEL_SHIFT_EN selects format).
// First block sample 2 clk after the href-low sample ending a band; no backpressure, a band ending mid read-out is dropped.
module dvp_ycbcr_block_top
    import dct_pkg::*;
#(
    parameter int WIDTH  = 24,
    parameter int HEIGHT = 16
) (
    input logic                  clk,
    input logic                  rst_n,
    dvp_ycbcr_block_top_if.slave bus
);

    localparam int NBLK    = WIDTH / BLOCK_N;
    localparam int BANK_SZ = BLOCK_N * WIDTH;
    localparam int DEPTH   = 2 * BANK_SZ;
    localparam int AW      = $clog2(DEPTH);
    localparam int CW      = $clog2(WIDTH + 1);
    localparam int RW      = $clog2(HEIGHT + 1);
    localparam int BW      = (NBLK > 1) ? $clog2(NBLK) : 1;
    localparam int NW      = $clog2(BLOCK_N * BLOCK_N);

    logic            href_d, href_q;
    logic            byte_ph_d, byte_ph_q;
    logic [7:0]      hi_d, hi_q;
    logic [CW-1:0]   col_d, col_q;
    logic [RW-1:0]   row_d, row_q;
    logic            line_pix_d, line_pix_q;
    logic            wr_bank_d, wr_bank_q;
    logic [AW-1:0]   wr_addr1_d, wr_addr1_q, wr_addr2_q;
    rd_state_t       rd_state_d, rd_state_q;
    logic            rd_bank_d, rd_bank_q;
    logic [BW-1:0]   rd_blk_d, rd_blk_q;
    logic [NW-1:0]   rd_n_d, rd_n_q;
    logic [AW-1:0]   rd_addr;
    logic [26:0]     rd_dat_d, rd_dat_q;
    logic            rv_d, rv_q;
    logic            rsob_d, rsob_q;
    dctPort_t [2:0]  out_d, out_q;

    logic            fall, pix_done, pix_keep, band_done;
    logic [15:0]     pix;
    logic            ycc_vld;
    logic signed [8:0] y_dat, cb_dat, cr_dat;

    logic [26:0]     mem [DEPTH];

    always_comb begin
        fall      = href_q && !bus.href;
        pix_done  = bus.href && byte_ph_q && !bus.vsync;
        pix_keep  = pix_done && (int'(col_q) < WIDTH) && (int'(row_q) < HEIGHT);
        band_done = fall && line_pix_q && !bus.vsync && (int'(row_q) < HEIGHT)
                    && ((int'(row_q) % BLOCK_N) == BLOCK_N - 1);
        pix       = {hi_q, bus.data};

        href_d     = bus.href;
        byte_ph_d  = bus.href && !byte_ph_q && !bus.vsync;
        hi_d       = (bus.href && !byte_ph_q) ? bus.data : hi_q;
        col_d      = col_q;
        row_d      = row_q;
        line_pix_d = line_pix_q;
        wr_bank_d  = wr_bank_q;

        if (bus.vsync) begin
            col_d      = '0;
            row_d      = '0;
            line_pix_d = 1'b0;
        end else begin
            if (pix_done) begin
                line_pix_d = 1'b1;
                if (int'(col_q) < WIDTH) begin
                    col_d = col_q + 1'b1;
                end
            end
            if (fall) begin
                col_d      = '0;
                line_pix_d = 1'b0;
                if (line_pix_q && (int'(row_q) < HEIGHT)) begin
                    row_d = row_q + 1'b1;
                end
            end
        end

        // The write address travels with the pixel so the swap cannot redirect in-flight pixels.
        wr_addr1_d = AW'(int'(wr_bank_q) * BANK_SZ + (int'(row_q) % BLOCK_N) * WIDTH + int'(col_q));

        rd_state_d = rd_state_q;
        rd_bank_d  = rd_bank_q;
        rd_blk_d   = rd_blk_q;
        rd_n_d     = rd_n_q;
        case (rd_state_q)
            RD_IDLE: begin
                if (band_done) begin
                    rd_state_d = RD_RUN;
                    rd_bank_d  = wr_bank_q;
                    wr_bank_d  = !wr_bank_q;
                    rd_blk_d   = '0;
                    rd_n_d     = '0;
                end
            end
            RD_RUN: begin
                rd_n_d = rd_n_q + 1'b1;
                if (rd_n_q == NW'(BLOCK_N * BLOCK_N - 1)) begin
                    rd_n_d = '0;
                    if (rd_blk_q == BW'(NBLK - 1)) begin
                        rd_state_d = RD_IDLE;
                    end else begin
                        rd_blk_d = rd_blk_q + 1'b1;
                    end
                end
            end
            default: rd_state_d = RD_IDLE;
        endcase

        rd_addr  = AW'(int'(rd_bank_q) * BANK_SZ + (int'(rd_n_q) / BLOCK_N) * WIDTH
                       + int'(rd_blk_q) * BLOCK_N + (int'(rd_n_q) % BLOCK_N));
        rd_dat_d = mem[rd_addr];
        rv_d     = (rd_state_q == RD_RUN);
        rsob_d   = (rd_state_q == RD_RUN) && (rd_n_q == '0);

        out_d = '0;
        if (rv_q) begin
            for (int k = 0; k < 3; k++) begin
                out_d[k].valid = 1'b1;
                out_d[k].sob   = rsob_q;
                out_d[k].data  = rd_dat_q[9*k +: 9];
            end
        end
    end

    rgb565_to_ycbcr u_conv (
        .clk     (clk),
        .rst_n   (rst_n),
        .pix_vld (pix_keep),
        .pix     (pix),
        .ycc_vld (ycc_vld),
        .y_dat   (y_dat),
        .cb_dat  (cb_dat),
        .cr_dat  (cr_dat)
    );

    always_ff @(posedge clk) begin
        if (ycc_vld) begin
            mem[wr_addr2_q] <= {cr_dat, cb_dat, y_dat};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            href_q     <= 1'b0;
            byte_ph_q  <= 1'b0;
            hi_q       <= '0;
            col_q      <= '0;
            row_q      <= '0;
            line_pix_q <= 1'b0;
            wr_bank_q  <= 1'b0;
            wr_addr1_q <= '0;
            wr_addr2_q <= '0;
            rd_state_q <= RD_IDLE;
            rd_bank_q  <= 1'b0;
            rd_blk_q   <= '0;
            rd_n_q     <= '0;
            rd_dat_q   <= '0;
            rv_q       <= 1'b0;
            rsob_q     <= 1'b0;
            out_q      <= '0;
        end else begin
            href_q     <= href_d;
            byte_ph_q  <= byte_ph_d;
            hi_q       <= hi_d;
            col_q      <= col_d;
            row_q      <= row_d;
            line_pix_q <= line_pix_d;
            wr_bank_q  <= wr_bank_d;
            wr_addr1_q <= wr_addr1_d;
            wr_addr2_q <= wr_addr1_q;
            rd_state_q <= rd_state_d;
            rd_bank_q  <= rd_bank_d;
            rd_blk_q   <= rd_blk_d;
            rd_n_q     <= rd_n_d;
            rd_dat_q   <= rd_dat_d;
            rv_q       <= rv_d;
            rsob_q     <= rsob_d;
            out_q      <= out_d;
        end
    end

    assign bus.out = out_q;

endmodule

// File: tb/tb_dvp_ycbcr_block_top.sv
// Scoreboard bench for dvp_ycbcr_block_top: expected block samples are queued as each band completes.
module tb_dvp_ycbcr_block_top;
    import dct_pkg::*;

    localparam int WIDTH        = 24;
    localparam int HEIGHT       = 16;
    localparam int NBLK         = WIDTH / 8;
    localparam int BAND_SAMPLES = 8 * WIDTH;
    localparam int LINE_GAP     = 8;

    typedef struct {
        logic              sob;
        logic signed [8:0] y;
        logic signed [8:0] cb;
        logic signed [8:0] cr;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks   = 0;
    int   failures = 0;
    int   run_len  = 0;
    exp_t sb_q[$];
    int   run_q[$];

    dvp_ycbcr_block_top_if bus();

    dvp_ycbcr_block_top #(.WIDTH(WIDTH), .HEIGHT(HEIGHT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [15:0] pix_val(input int x, input int y, input int mode);
        if (mode == 0) begin
            return 16'h0102;
        end
        return {5'(x), 6'(y), 5'(x + 3 * y)};
    endfunction

    function automatic exp_t ref_sample(input logic [15:0] p, input int mode, input logic sob);
        exp_t e;
        int r, g, b, yv, cbv, crv;
        if (mode == 0) begin
`ifdef LEVEL_SHIFT_EN
            yv = -108; cbv = -3; crv = -15;
`else
            yv = 20; cbv = 125; crv = 113;
`endif
        end else begin
            r   = int'({p[15:11], p[15:13]});
            g   = int'({p[10:5], p[10:9]});
            b   = int'({p[4:0], p[4:2]});
            yv  = (77 * r + 150 * g + 29 * b) >>> 8;
            cbv = (-43 * r - 85 * g + 128 * b) >>> 8;
            crv = (128 * r - 107 * g - 21 * b) >>> 8;
`ifdef LEVEL_SHIFT_EN
            yv = yv - 128;
`else
            cbv = cbv + 128;
            crv = crv + 128;
            if (cbv < 0) cbv = 0; else if (cbv > 255) cbv = 255;
            if (crv < 0) crv = 0; else if (crv > 255) crv = 255;
`endif
        end
        e.sob = sob;
        e.y   = 9'(yv);
        e.cb  = 9'(cbv);
        e.cr  = 9'(crv);
        return e;
    endfunction

    always begin : monitor
        exp_t     e;
        dctPort_t wy, wcb, wcr;
        @(posedge clk);
        #1;
        if (!rst_n) begin
            run_len = 0;
        end else if (bus.out[Y_CH].valid || bus.out[CB_CH].valid || bus.out[CR_CH].valid) begin
            run_len++;
            checks++;
            if (sb_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_sample: got valid=%b%b%b y=%0d, required no output",
                         bus.out[Y_CH].valid, bus.out[CB_CH].valid, bus.out[CR_CH].valid,
                         $signed(bus.out[Y_CH].data));
            end else begin
                e   = sb_q.pop_front();
                wy  = '{valid: 1'b1, sob: e.sob, data: e.y};
                wcb = '{valid: 1'b1, sob: e.sob, data: e.cb};
                wcr = '{valid: 1'b1, sob: e.sob, data: e.cr};
                if (bus.out[Y_CH] !== wy || bus.out[CB_CH] !== wcb || bus.out[CR_CH] !== wcr) begin
                    failures++;
                    $display("FAIL sample: got y=%0d cb=%0d cr=%0d sob=%b%b%b valid=%b%b%b, required y=%0d cb=%0d cr=%0d sob=%b",
                             $signed(bus.out[Y_CH].data), $signed(bus.out[CB_CH].data),
                             $signed(bus.out[CR_CH].data), bus.out[Y_CH].sob, bus.out[CB_CH].sob,
                             bus.out[CR_CH].sob, bus.out[Y_CH].valid, bus.out[CB_CH].valid,
                             bus.out[CR_CH].valid, e.y, e.cb, e.cr, e.sob);
                end
            end
        end else if (run_len > 0) begin
            run_q.push_back(run_len);
            run_len = 0;
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_band(input int band, input int mode);
        for (int k = 0; k < NBLK; k++) begin
            for (int n = 0; n < 64; n++) begin
                sb_q.push_back(ref_sample(pix_val(8 * k + n % 8, band * 8 + n / 8, mode), mode, n == 0));
            end
        end
    endtask

    task automatic send_line(input int y, input int npix, input bit odd, input int mode, input bit lat);
        logic [15:0] p;
        for (int x = 0; x < npix; x++) begin
            p = pix_val(x, y, mode);
            bus.href = 1'b1;
            bus.data = p[15:8];
            tick();
            bus.data = p[7:0];
            tick();
        end
        if (odd) begin
            bus.href = 1'b1;
            bus.data = 8'hE7;
            tick();
        end
        bus.href = 1'b0;
        bus.data = 8'h00;
        if (npix > 0 && y < HEIGHT && y % 8 == 7) begin
            push_band(y / 8, mode);
            if (lat) begin
                tick(2);
                checks++;
                if (bus.out[Y_CH].valid !== 1'b0) begin
                    failures++;
                    $display("FAIL latency_early: valid=%b one clk after band end, required 0", bus.out[Y_CH].valid);
                end
                tick();
                checks++;
                if (bus.out[Y_CH].valid !== 1'b1 || bus.out[Y_CH].sob !== 1'b1) begin
                    failures++;
                    $display("FAIL latency_first: valid=%b sob=%b two clk after band end, required 1 1",
                             bus.out[Y_CH].valid, bus.out[Y_CH].sob);
                end
            end
        end
        tick(LINE_GAP);
    endtask

    task automatic send_frame(input int nlines, input int npix, input bit odd, input int mode, input bit lat);
        bus.vsync = 1'b1;
        tick(2);
        bus.vsync = 1'b0;
        tick(4);
        for (int y = 0; y < nlines; y++) begin
            send_line(y, npix, odd, mode, lat);
        end
    endtask

    task automatic drain(input string name, input int exp_runs);
        int budget;
        int r;
        budget = 3000;
        while (sb_q.size() != 0 && budget > 0) begin
            tick();
            budget--;
        end
        tick(8);
        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL %s_drain: %0d samples never produced, required 0", name, sb_q.size());
            sb_q.delete();
        end
        checks++;
        if (run_q.size() != exp_runs) begin
            failures++;
            $display("FAIL %s_bursts: got %0d bursts, required %0d", name, run_q.size(), exp_runs);
        end
        while (run_q.size() > 0) begin
            r = run_q.pop_front();
            checks++;
            if (r != BAND_SAMPLES) begin
                failures++;
                $display("FAIL %s_burst_len: got %0d contiguous valid, required %0d", name, r, BAND_SAMPLES);
            end
        end
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        bus.vsync = 1'b0;
        for (int i = 0; i < 20; i++) begin
            bus.href = 1'($urandom_range(0, 1));
            bus.data = 8'($urandom);
            tick();
            checks++;
            if (bus.out !== '0) begin
                failures++;
                $display("FAIL reset_hold: out=%h, required 0", bus.out);
            end
        end
        bus.href = 1'b0;
        bus.data = 8'h00;
        rst_n    = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if (bus.out[Y_CH].valid !== 1'b0 || bus.out[CB_CH].valid !== 1'b0 || bus.out[CR_CH].valid !== 1'b0) begin
                failures++;
                $display("FAIL reset_idle: valid=%b%b%b after release, required 000",
                         bus.out[Y_CH].valid, bus.out[CB_CH].valid, bus.out[CR_CH].valid);
            end
        end
    endtask

    task automatic test_const_pixel();
        send_frame(HEIGHT, WIDTH, 1'b0, 0, 1'b0);
        drain("const_pixel", 2);
    endtask

    task automatic test_order_latency();
        send_frame(HEIGHT, WIDTH, 1'b0, 1, 1'b1);
        drain("order_latency", 2);
    endtask

    task automatic test_long_line();
        send_frame(HEIGHT, WIDTH + 1, 1'b1, 1, 1'b0);
        drain("long_line", 2);
    endtask

    task automatic test_extra_lines();
        send_frame(HEIGHT + 8, WIDTH, 1'b0, 1, 1'b0);
        drain("extra_lines", 2);
    endtask

    task automatic test_mid_vsync();
        send_frame(11, WIDTH, 1'b0, 1, 1'b0);
        send_frame(HEIGHT, WIDTH, 1'b0, 1, 1'b0);
        drain("mid_vsync", 3);
    endtask

    task automatic test_reset_readout();
        send_frame(8, WIDTH, 1'b0, 1, 1'b0);
        checks++;
        if (bus.out[Y_CH].valid !== 1'b1) begin
            failures++;
            $display("FAIL readout_active: valid=%b before reset, required 1", bus.out[Y_CH].valid);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.out !== '0) begin
            failures++;
            $display("FAIL reset_async: out=%h right after reset, required 0", bus.out);
        end
        sb_q.delete();
        run_q.delete();
        tick(3);
        rst_n = 1'b1;
        tick(4);
        send_frame(HEIGHT, WIDTH, 1'b0, 1, 1'b0);
        drain("after_reset", 2);
    endtask

    initial begin
        bus.vsync = 1'b0;
        bus.href  = 1'b0;
        bus.data  = 8'h00;
        test_reset();
        test_const_pixel();
        test_order_latency();
        test_long_line();
        test_extra_lines();
        test_mid_vsync();
        test_reset_readout();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dvp_ycbcr_block_top.md
Name: dvp_ycbcr_block_top

Overview:
- Front end of the JPEG/DCT path.
- Captures a DVP-style camera stream (vsync, href, 8-bit bytes, two bytes per RGB565 pixel) and converts each pixel to YCbCr.
- Buffers 8-row bands and re-emits them as 8x8 blocks, one sample per clock on three parallel channel ports (Y, Cb, Cr) feeding the DCT stage.

Parameters:
- WIDTH, 24: active pixels per line; multiple of 8.
- HEIGHT, 16: active lines per frame; multiple of 8.
- Positional order: WIDTH, HEIGHT.

Ports:
- clk  input  1  single clock; all inputs are synchronous to it; the camera pixel clock drives it at system level.
- rst_n  input  1  reset; asynchronous, active-low.
- vsync  input  1  frame sync, active high.
- href  input  1  line valid; one data byte per clk while high.
- data  input  8  camera byte.
- out  output  dctPort_t[3]  index 0 = Y, 1 = Cb, 2 = Cr.
- dctPort_t fields: valid (1), sob (1, start of block), data (signed 9).

Behaviour:
- Reset (asynchronous): all counters, byte phase and bank select clear; every out[k].valid=0, sob=0, data=0.
- Capture:
  - Each clk with href=1 captures one byte.
  - Byte phase 0 is the high byte (RRRRRGGG); phase 1 is the low byte (GGGBBBBB); the pixel completes on phase 1.
  - Byte phase clears whenever href=0; an odd trailing byte is discarded.
  - Column counter increments per pixel; pixels with column >= WIDTH are dropped.
  - Row counter increments on the href falling edge only if at least one pixel was captured; rows >= HEIGHT are ignored.
- vsync=1: clears column, row, byte phase and the write-band fill. A read-out already in progress completes.
- Colour conversion:
  - Expand by bit replication: R8={R5,R5[4:2]}, G8={G6,G6[5:4]}, B8={B5,B5[4:2]}.
  - Y=(77R+150G+29B)>>8.
  - Cb=(-43R-85G+128B)>>>8.
  - Cr=(128R-107G-21B)>>>8.
  - Shifts are arithmetic (floor); intermediates are 18-bit signed.
  - Two-stage pipeline.
- Level shift (LEVEL_SHIFT_EN defined): out Y = Y-128; Cb/Cr are the signed values above; range -128..127.
- Buffer:
  - Two banks (ping-pong), each 8 rows x WIDTH x 3 channels.
  - Writes fill the active bank.
  - When the 8th row of a band ends (href falling), banks swap and read-out of the filled bank starts.
- Read-out:
  - WIDTH/8 blocks, left to right; within a block, row-major 8x8.
  - 64 consecutive valid cycles per block, no gaps between blocks.
  - sob=1 on sample 0 of each block; all three channels in lockstep.
- Latency: first valid sample appears 2 clk after the clock in which href=0 is sampled ending the band's 8th row.
- Read-out takes 8*WIDTH clocks; band fill takes at least 16*WIDTH clocks, so no overlap occurs in normal operation.
- If a band completes while read-out is still busy, that new band is dropped (no swap) and the write bank is reused.
- Per frame: (WIDTH/8)*(HEIGHT/8) blocks per channel.

Optional Feature:
- Macro LEVEL_SHIFT_EN.
- Defined: signed outputs as above (Y-128, chroma centred on 0).
- Undefined: unsigned JFIF outputs zero-extended into data:
  - Y as computed;
  - Cb+128 and Cr+128, each saturated to 0..255.

Decomposition:
- Package dct_pkg holds:
  - dctPort_t;
  - BLOCK_N=8;
  - conversion coefficients;
  - channel index constants Y_CH=0, CB_CH=1, CR_CH=2.
- One sub-module: rgb565_to_ycbcr (expansion plus 2-stage multiply/add pipeline).
- Capture, counters, ping-pong RAM and read sequencer live in the top.

Test Plan:
- Reset: hold rst_n=0 with random href/data -> all valid=0; release with no href -> valid stays 0.
- Constant pixel: vsync pulse, 16 lines of 24 pixels of bytes 0x01,0x02 (pixel 0x0102) -> 6 blocks of 64 samples:
  - with LEVEL_SHIFT_EN: Y=-108, Cb=-3, Cr=-15;
  - without: Y=20, Cb=125, Cr=113.
- Ordering: pixel value encodes (x,y) gradient -> block k sample n equals pixel (8k+n%8, band*8+n/8); sob only at n=0.
- Latency and throughput: the 8th line's href falling edge -> first valid exactly 2 clk later; 192 contiguous valid cycles per band; 384 per frame.
- Boundaries:
  - line with 25 pixels plus an odd byte -> extra data ignored;
  - 17 lines -> line 17 ignored;
  - mid-frame vsync -> counters restart and the next frame is correct.
- Reset mid read-out -> valid drops asynchronously; the next frame is clean.
